debug_snapshot_streamer: RTL and testbench

Parametrised debug readout block for the pipeline debug unit. It accepts a flat bus of NUM_WORDS probe words gathered from the pipeline latches and freezes all of them into a snapshot bank in a single cycle. A registered random-access read port exposes the bank, and a byte-stream engine with a valid/ready handshake sends the frozen snapshot to the UART transmitter.

---
 rtl/debug_snapshot_streamer_if.sv | 34 +++
 rtl/debug_snapshot_streamer.sv | 180 ++++++++++++++++++
 tb/tb_debug_snapshot_streamer.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/debug_snapshot_streamer_if.sv
// Debug snapshot streamer bundle: probe capture, random-access read and byte-stream handshake.
// Latency: n/a (wiring only).
// Backpressure: tx_ready from the sink stalls the byte stream; tx_data/tx_valid hold while stalled.
// Ports: probe_bus/cap_req/stream_req/sel/tx_ready flow into the streamer;
//        sel_data/snap_valid/busy/cap_drop/tx_data/tx_valid/done flow out of it.
// Modports: slave = streamer side, master = debug unit / UART sink side.
interface debug_snapshot_streamer_if #(
  parameter int NUM_WORDS = 24,
  parameter int WORD_W    = 32,
  parameter int IDX_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1
);
  logic [NUM_WORDS*WORD_W-1:0] probe_bus;
  logic                        cap_req;
  logic                        stream_req;
  logic [IDX_W-1:0]            sel;
  logic [WORD_W-1:0]           sel_data;
  logic                        snap_valid;
  logic                        busy;
  logic                        cap_drop;
  logic [7:0]                  tx_data;
  logic                        tx_valid;
  logic                        tx_ready;
  logic                        done;

  modport slave (
    input  probe_bus, cap_req, stream_req, sel, tx_ready,
    output sel_data, snap_valid, busy, cap_drop, tx_data, tx_valid, done
  );

  modport master (
    output probe_bus, cap_req, stream_req, sel, tx_ready,
    input  sel_data, snap_valid, busy, cap_drop, tx_data, tx_valid, done
  );
endinterface

// File: rtl/debug_snapshot_streamer.sv
// Debug snapshot streamer: freezes NUM_WORDS probe words into a bank, exposes them on a
// registered read port and streams them as a byte frame (0xA5, words LSB first, [checksum]).
// Latency: capture 1 edge, sel_data 1 cycle; header valid the cycle after stream_req.
// Backpressure: tx_valid/tx_ready; each stalled cycle holds the byte and extends the frame by one.
// Ports: clk, rst (async, active-high) plus the dbg bundle (slave modport).
// Optional feature: define DBG_STREAM_CHECKSUM_EN to append an XOR checksum byte.
module debug_snapshot_streamer #(
  parameter int NUM_WORDS = 24,
  parameter int WORD_W    = 32,
  parameter int IDX_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  debug_snapshot_streamer_if.slave dbg
);

  localparam int                 BYTES     = WORD_W / 8;
  localparam int                 BIDX_W    = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [IDX_W-1:0]   LAST_WORD = IDX_W'(NUM_WORDS - 1);
  localparam logic [BIDX_W-1:0]  LAST_BYTE = BIDX_W'(BYTES - 1);
  localparam logic [7:0]         HDR_BYTE  = 8'hA5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_DATA,
`ifdef DBG_STREAM_CHECKSUM_EN
    S_CHK,
`endif
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    word_idx_q, word_idx_d;
  logic [BIDX_W-1:0]   byte_idx_q, byte_idx_d;
  logic [WORD_W-1:0]   bank_q [NUM_WORDS];
  logic [WORD_W-1:0]   sel_data_q;
  logic                snap_valid_q;
  logic                cap_drop_q;
  logic [WORD_W-1:0]   sel_word;
  logic [WORD_W-1:0]   cur_word;
  logic [7:0]          cur_byte;
  logic [7:0]          tx_data_c;
  logic                tx_valid_c;
`ifdef DBG_STREAM_CHECKSUM_EN
  logic [7:0]          chk_q, chk_d;
`endif

  // Mux-by-compare rather than direct indexing: an index beyond NUM_WORDS naturally
  // yields zero and no index-width assumptions leak into the read path.
  always_comb begin
    sel_word = '0;
    cur_word = '0;
    for (int k = 0; k < NUM_WORDS; k++) begin
      if (int'(dbg.sel) == k)    sel_word = bank_q[k];
      if (int'(word_idx_q) == k) cur_word = bank_q[k];
    end
  end

  assign cur_byte = cur_word[{byte_idx_q, 3'b000} +: 8];

  // Capture is only legal in IDLE so a frame in flight always sees a coherent bank.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NUM_WORDS; k++) bank_q[k] <= '0;
      snap_valid_q <= 1'b0;
      cap_drop_q   <= 1'b0;
    end else if (dbg.cap_req) begin
      if (state_q == S_IDLE) begin
        for (int k = 0; k < NUM_WORDS; k++) bank_q[k] <= dbg.probe_bus[k*WORD_W +: WORD_W];
        snap_valid_q <= 1'b1;
        cap_drop_q   <= 1'b0;
      end else begin
        cap_drop_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sel_data_q <= '0;
    else     sel_data_q <= sel_word;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      word_idx_q <= '0;
      byte_idx_q <= '0;
`ifdef DBG_STREAM_CHECKSUM_EN
      chk_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      word_idx_q <= word_idx_d;
      byte_idx_q <= byte_idx_d;
`ifdef DBG_STREAM_CHECKSUM_EN
      chk_q      <= chk_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    word_idx_d = word_idx_q;
    byte_idx_d = byte_idx_q;
    tx_data_c  = 8'h00;
    tx_valid_c = 1'b0;
`ifdef DBG_STREAM_CHECKSUM_EN
    chk_d      = chk_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (dbg.stream_req) begin
          state_d    = S_HDR;
          word_idx_d = '0;
          byte_idx_d = '0;
`ifdef DBG_STREAM_CHECKSUM_EN
          chk_d      = '0;
`endif
        end
      end
      S_HDR: begin
        tx_valid_c = 1'b1;
        tx_data_c  = HDR_BYTE;
        if (dbg.tx_ready) begin
          state_d = S_DATA;
`ifdef DBG_STREAM_CHECKSUM_EN
          chk_d   = chk_q ^ HDR_BYTE;
`endif
        end
      end
      S_DATA: begin
        tx_valid_c = 1'b1;
        tx_data_c  = cur_byte;
        if (dbg.tx_ready) begin
`ifdef DBG_STREAM_CHECKSUM_EN
          chk_d = chk_q ^ cur_byte;
`endif
          if (byte_idx_q == LAST_BYTE) begin
            byte_idx_d = '0;
            if (word_idx_q == LAST_WORD) begin
`ifdef DBG_STREAM_CHECKSUM_EN
              state_d = S_CHK;
`else
              state_d = S_DONE;
`endif
            end else begin
              word_idx_d = word_idx_q + 1'b1;
            end
          end else begin
            byte_idx_d = byte_idx_q + 1'b1;
          end
        end
      end
`ifdef DBG_STREAM_CHECKSUM_EN
      S_CHK: begin
        tx_valid_c = 1'b1;
        tx_data_c  = chk_q;
        if (dbg.tx_ready) state_d = S_DONE;
      end
`endif
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Handshake outputs decode straight from registered state, so reset drops them at once.
  assign dbg.tx_valid   = tx_valid_c;
  assign dbg.tx_data    = tx_data_c;
  assign dbg.busy       = (state_q != S_IDLE);
  assign dbg.done       = (state_q == S_DONE);
  assign dbg.sel_data   = sel_data_q;
  assign dbg.snap_valid = snap_valid_q;
  assign dbg.cap_drop   = cap_drop_q;

endmodule

// File: tb/tb_debug_snapshot_streamer.sv
// Bench for debug_snapshot_streamer: directed frames with literal expectations plus a random
// phase, all continuously compared against a frame-queue reference model.
// Clock period 10; inputs change 2 time units after the rising edge, outputs sampled on the falling edge.
module tb_debug_snapshot_streamer;
  localparam int NW  = 2;
  localparam int WW  = 32;
  localparam int IW  = 2;  // one spare bit so out-of-range selects are reachable
  localparam int BPW = WW / 8;
`ifdef DBG_STREAM_CHECKSUM_EN
  localparam int B = 2 + NW * BPW;
`else
  localparam int B = 1 + NW * BPW;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  debug_snapshot_streamer_if #(.NUM_WORDS(NW), .WORD_W(WW), .IDX_W(IW)) dif ();

  debug_snapshot_streamer #(.NUM_WORDS(NW), .WORD_W(WW), .IDX_W(IW)) dut (
    .clk (clk),
    .rst (rst),
    .dbg (dif)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a snapshot array and the queue of frame bytes still to be sent.
  logic [WW-1:0] m_bank [NW];
  logic [7:0]    m_frame [$];
  logic          m_done = 1'b0;
  logic          m_snap = 1'b0;
  logic          m_drop = 1'b0;
  logic [WW-1:0] m_sel  = '0;
  logic          m_idle;
  logic [7:0]    m_x;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      foreach (m_bank[k]) m_bank[k] = '0;
      m_frame.delete();
      m_done = 1'b0;
      m_snap = 1'b0;
      m_drop = 1'b0;
      m_sel  = '0;
    end else begin
      m_sel = '0;
      foreach (m_bank[k]) if (k == int'(dif.sel)) m_sel = m_bank[k];
      m_idle = (m_frame.size() == 0) && !m_done;
      if (m_done) begin
        m_done = 1'b0;
      end else if (m_frame.size() != 0 && dif.tx_ready) begin
        void'(m_frame.pop_front());
        if (m_frame.size() == 0) m_done = 1'b1;
      end
      if (dif.cap_req) begin
        if (m_idle) begin
          foreach (m_bank[k]) m_bank[k] = dif.probe_bus[k*WW +: WW];
          m_snap = 1'b1;
          m_drop = 1'b0;
        end else begin
          m_drop = 1'b1;
        end
      end
      if (m_idle && dif.stream_req) begin
        m_frame.push_back(8'hA5);
        m_x = 8'hA5;
        foreach (m_bank[w]) begin
          for (int b = 0; b < BPW; b++) begin
            m_frame.push_back(m_bank[w][8*b +: 8]);
            m_x = m_x ^ m_bank[w][8*b +: 8];
          end
        end
`ifdef DBG_STREAM_CHECKSUM_EN
        m_frame.push_back(m_x);
`endif
      end
    end
  end

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    if (!rst) begin
      check("tx_valid", dif.tx_valid, m_frame.size() != 0);
      if (m_frame.size() != 0) check("tx_data", dif.tx_data, m_frame[0]);
      check("done", dif.done, m_done);
      check("busy", dif.busy, (m_frame.size() != 0) || m_done);
      check("snap_valid", dif.snap_valid, m_snap);
      check("cap_drop", dif.cap_drop, m_drop);
      check("sel_data", dif.sel_data, m_sel);
    end
  end

  // Record every accepted byte for the literal frame comparisons.
  logic [7:0] got_q [$];
  logic [7:0] exp_q [$];
  always @(negedge clk) begin
    if (!rst && dif.tx_valid && dif.tx_ready) got_q.push_back(dif.tx_data);
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic cmp_frame(input string nm);
    check({nm, "_len"}, got_q.size(), exp_q.size());
    foreach (exp_q[i]) if (i < got_q.size()) check(nm, got_q[i], exp_q[i]);
  endtask

  // Issues stream_req (optionally with cap_req), drives tx_ready from pat per cycle and an
  // optional mid-frame cap_req; returns edges from the request edge until done is seen.
  task automatic run_frame(input bit with_cap, input logic [7:0] pat, input int pat_len,
                           input int cap_at, output int cyc);
    got_q.delete();
    dif.stream_req = 1'b1;
    dif.cap_req    = with_cap;
    dif.tx_ready   = 1'b1;
    step();
    dif.stream_req = 1'b0;
    dif.cap_req    = 1'b0;
    dif.tx_ready   = (pat_len > 0) ? pat[0] : 1'b1;
    cyc = 0;
    while (cyc < 100) begin
      @(posedge clk);
      cyc++;
      #1;
      if (dif.done) break;
      #1;
      dif.tx_ready = (cyc < pat_len) ? pat[cyc] : 1'b1;
      dif.cap_req  = (cyc == cap_at);
    end
    #1;
    dif.tx_ready = 1'b1;
    dif.cap_req  = 1'b0;
  endtask

  int cyc;

  initial begin
    dif.probe_bus  = '0;
    dif.cap_req    = 1'b0;
    dif.stream_req = 1'b0;
    dif.sel        = '0;
    dif.tx_ready   = 1'b1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_tx_valid", dif.tx_valid, 0);
    check("rst_tx_data", dif.tx_data, 0);
    check("rst_busy", dif.busy, 0);
    check("rst_done", dif.done, 0);
    check("rst_sel_data", dif.sel_data, 0);
    check("rst_snap_valid", dif.snap_valid, 0);
    check("rst_cap_drop", dif.cap_drop, 0);
    #1;
    rst = 1'b0;

    // Capture and random-access read.
    dif.probe_bus = {32'hAABBCCDD, 32'h11223344};
    dif.cap_req   = 1'b1;
    step();
    dif.cap_req = 1'b0;
    dif.sel     = 2'd1;
    step();
    check("read_sel1", dif.sel_data, 32'hAABBCCDD);
    check("read_snap_valid", dif.snap_valid, 1);
    dif.sel = 2'd3;
    step();
    check("read_sel3", dif.sel_data, 0);
    dif.sel = 2'd0;
    step();
    check("read_sel0", dif.sel_data, 32'h11223344);

    // Full-rate frame.
    run_frame(1'b0, 8'h00, 0, -1, cyc);
    check("frame_cycles", cyc, B);
    exp_q = '{8'hA5, 8'h44, 8'h33, 8'h22, 8'h11, 8'hDD, 8'hCC, 8'hBB, 8'hAA};
`ifdef DBG_STREAM_CHECKSUM_EN
    exp_q.push_back(8'hE1);
`endif
    cmp_frame("frame_rdy1");
    step();

    // Backpressure: tx_ready 1,0,0,1 then held high.
    run_frame(1'b0, 8'b0000_1001, 4, -1, cyc);
    check("bp_cycles", cyc, B + 2);
    cmp_frame("frame_bp");
    step();

    // Capture attempted mid-frame: dropped, frame keeps the old words.
    dif.probe_bus = {32'h99887766, 32'h55443322};
    run_frame(1'b0, 8'h00, 0, 3, cyc);
    check("midcap_cycles", cyc, B);
    cmp_frame("frame_midcap");
    check("midcap_drop", dif.cap_drop, 1);
    step();
    dif.cap_req = 1'b1;
    step();
    dif.cap_req = 1'b0;
    check("drop_cleared", dif.cap_drop, 0);
    step();

    // Simultaneous capture and stream: frame carries the new words.
    dif.probe_bus = {32'h05060708, 32'h01020304};
    run_frame(1'b1, 8'h00, 0, -1, cyc);
    exp_q = '{8'hA5, 8'h04, 8'h03, 8'h02, 8'h01, 8'h08, 8'h07, 8'h06, 8'h05};
`ifdef DBG_STREAM_CHECKSUM_EN
    exp_q.push_back(8'hAD);
`endif
    cmp_frame("frame_simul");
    step();

    // Reset while byte 4 of the frame is on the bus.
    dif.stream_req = 1'b1;
    step();
    dif.stream_req = 1'b0;
    repeat (4) step();
    check("pre_rst_byte4", dif.tx_data, 8'h01);
    rst = 1'b1;
    #1;
    check("arst_tx_valid", dif.tx_valid, 0);
    check("arst_busy", dif.busy, 0);
    check("arst_done", dif.done, 0);
    check("arst_sel_data", dif.sel_data, 0);
    check("arst_snap_valid", dif.snap_valid, 0);
    check("arst_cap_drop", dif.cap_drop, 0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    step();
    run_frame(1'b0, 8'h00, 0, -1, cyc);
    check("zero_frame_cycles", cyc, B);
    exp_q = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
`ifdef DBG_STREAM_CHECKSUM_EN
    exp_q.push_back(8'hA5);
`endif
    cmp_frame("frame_zero");
    step();

    // Random phase, checked every cycle by the model.
    for (int i = 0; i < 600; i++) begin
      dif.probe_bus  = {$urandom, $urandom};
      dif.cap_req    = ($urandom_range(0, 7) == 0);
      dif.stream_req = ($urandom_range(0, 5) == 0);
      dif.sel        = IW'($urandom_range(0, 3));
      dif.tx_ready   = ($urandom_range(0, 3) != 0);
      step();
    end
    dif.cap_req    = 1'b0;
    dif.stream_req = 1'b0;
    dif.tx_ready   = 1'b1;
    repeat (3 * B) step();
    check("drain_idle", dif.busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
